// File: rtl/sparse_pkg.sv
// ----------------------------------------------------------------------------
// sparse_pkg
// Shared constants and types for the sparse selection generator.
//   TILE_ELEMS / BLK_ELEMS : tile geometry (16 elements, 4 blocks of 4)
//   blk_idx_t / elem_idx_t : 2-bit block and in-block element indices
//   beat_t                 : one output beat {sel_level0, sel_level1,
//                            lane_vld, last}
//   elem_bit()             : one-hot mask bit for (block, element)
// ----------------------------------------------------------------------------
package sparse_pkg;

  localparam int TILE_ELEMS = 16;
  localparam int BLK_ELEMS  = 4;

  typedef logic [1:0] blk_idx_t;
  typedef logic [1:0] elem_idx_t;

  typedef struct packed {
    logic [3:0] sel_level0;
    logic [7:0] sel_level1;
    logic [3:0] lane_vld;
    logic       last;
  } beat_t;

  function automatic logic [TILE_ELEMS-1:0] elem_bit(input blk_idx_t  blk,
                                                     input elem_idx_t elem);
    elem_bit = TILE_ELEMS'(1) << {blk, elem};
  endfunction

endpackage

// File: rtl/sparse_sel_gen_if.sv
// ----------------------------------------------------------------------------
// sparse_sel_gen_if
// Tile input handshake and beat output bus of sparse_sel_gen.
//   master : tile source / beat consumer (drives in_*, out_ready)
//   slave  : sparse_sel_gen (drives in_ready and all beat outputs)
// Optional macro SPARSE_SEL_ZERO_SKIP_EN adds the zero_tile_cnt pulse.
// ----------------------------------------------------------------------------
interface sparse_sel_gen_if #(parameter int ELEM_W = 8);

  logic                 in_valid;
  logic                 in_ready;
  logic [16*ELEM_W-1:0] in_data;
  logic [15:0]          in_mask;

  logic                 out_valid;
  logic                 out_ready;
  logic [16*ELEM_W-1:0] out_data;
  logic [3:0]           sel_level0;
  logic [7:0]           sel_level1;
  logic [3:0]           lane_vld;
  logic                 out_last;
  logic [1:0]           beat_idx;

`ifdef SPARSE_SEL_ZERO_SKIP_EN
  logic                 zero_tile_cnt;

  modport master (
    output in_valid, in_data, in_mask, out_ready,
    input  in_ready, out_valid, out_data, sel_level0, sel_level1,
           lane_vld, out_last, beat_idx, zero_tile_cnt
  );

  modport slave (
    input  in_valid, in_data, in_mask, out_ready,
    output in_ready, out_valid, out_data, sel_level0, sel_level1,
           lane_vld, out_last, beat_idx, zero_tile_cnt
  );
`else
  modport master (
    output in_valid, in_data, in_mask, out_ready,
    input  in_ready, out_valid, out_data, sel_level0, sel_level1,
           lane_vld, out_last, beat_idx
  );

  modport slave (
    input  in_valid, in_data, in_mask, out_ready,
    output in_ready, out_valid, out_data, sel_level0, sel_level1,
           lane_vld, out_last, beat_idx
  );
`endif

endinterface

// File: rtl/sparse_sel_gen_lead2_pick.sv
// ----------------------------------------------------------------------------
// lead2_pick
// Finds the lowest and second-lowest set bits of a 4-bit vector.
//   i_vec          : candidate vector
//   o_first        : index of lowest set bit (0 when none)
//   o_first_vld    : a first bit exists
//   o_second       : index of next set bit (0 when none)
//   o_second_vld   : a second bit exists
// ----------------------------------------------------------------------------
module lead2_pick (
  input  logic [3:0] i_vec,
  output logic [1:0] o_first,
  output logic       o_first_vld,
  output logic [1:0] o_second,
  output logic       o_second_vld
);

  always_comb begin
    o_first      = 2'd0;
    o_first_vld  = 1'b0;
    o_second     = 2'd0;
    o_second_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i_vec[i]) begin
        if (!o_first_vld) begin
          o_first     = 2'(i);
          o_first_vld = 1'b1;
        end else if (!o_second_vld) begin
          o_second     = 2'(i);
          o_second_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sparse_sel_gen.sv
// ----------------------------------------------------------------------------
// sparse_sel_gen
// Accepts a 4x4 tile plus non-zero mask and walks the mask over 1-4 beats,
// driving the two-level sparse mux selects so up to four non-zero elements
// reach the mux output per beat. Tile data is held for all beats.
//   clk, rst_n : clock, async active-low reset
//   bus        : sparse_sel_gen_if.slave (tile in, beat out handshakes)
// Optional macro SPARSE_SEL_ZERO_SKIP_EN: all-zero tiles are accepted and
// dropped without a beat, pulsing bus.zero_tile_cnt instead.
//
// State table
//   S_IDLE | no tile pending, out_valid = 0
//   S_BUSY | beat presented; r_pend holds mask bits not yet emitted
// ----------------------------------------------------------------------------
module sparse_sel_gen
  import sparse_pkg::*;
#(
  parameter int ELEM_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  sparse_sel_gen_if.slave bus
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                         r_state;
  logic [TILE_ELEMS*ELEM_W-1:0]   r_data;
  logic [TILE_ELEMS-1:0]          r_pend;
  beat_t                          r_beat;
  logic [1:0]                     r_beat_idx;

  logic                  w_valid;
  logic                  w_hs;
  logic                  w_in_ready;
  logic                  w_acc;
  logic                  w_load;
  logic [TILE_ELEMS-1:0] w_src;
  logic [TILE_ELEMS-1:0] w_emit;
  logic [TILE_ELEMS-1:0] w_rem;
  logic [3:0]            w_blk_vec;
  logic [3:0]            w_e0_vec;
  logic [3:0]            w_e1_vec;
  blk_idx_t              w_blk0, w_blk1;
  logic                  w_blk0_vld, w_blk1_vld;
  elem_idx_t             w_f0, w_s0, w_f1, w_s1;
  logic                  w_f0_vld, w_s0_vld, w_f1_vld, w_s1_vld;
  beat_t                 w_beat;

  assign w_valid    = (r_state == S_BUSY);
  assign w_hs       = w_valid & bus.out_ready;
  assign w_in_ready = ~w_valid | (w_hs & r_beat.last);
  assign w_acc      = bus.in_valid & w_in_ready;

`ifdef SPARSE_SEL_ZERO_SKIP_EN
  logic w_zero_tile;
  logic r_zero_pulse;
  assign w_zero_tile       = (bus.in_mask == '0);
  assign w_load            = w_acc & ~w_zero_tile;
  assign bus.zero_tile_cnt = r_zero_pulse;
`else
  assign w_load = w_acc;
`endif

  // Next beat is formed either from a freshly accepted mask or from the
  // bits left over after the beat currently on the outputs.
  assign w_src = w_acc ? bus.in_mask : r_pend;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      w_blk_vec[b] = |w_src[b*BLK_ELEMS +: BLK_ELEMS];
    end
  end

  lead2_pick u_blk_pick (
    .i_vec        (w_blk_vec),
    .o_first      (w_blk0),
    .o_first_vld  (w_blk0_vld),
    .o_second     (w_blk1),
    .o_second_vld (w_blk1_vld)
  );

  // Slot 0 needs no qualification: with no block valid, w_src is all zero.
  assign w_e0_vec = w_src[{w_blk0, 2'b00} +: BLK_ELEMS];
  assign w_e1_vec = w_blk1_vld ? w_src[{w_blk1, 2'b00} +: BLK_ELEMS] : 4'b0000;

  lead2_pick u_elem0_pick (
    .i_vec        (w_e0_vec),
    .o_first      (w_f0),
    .o_first_vld  (w_f0_vld),
    .o_second     (w_s0),
    .o_second_vld (w_s0_vld)
  );

  lead2_pick u_elem1_pick (
    .i_vec        (w_e1_vec),
    .o_first      (w_f1),
    .o_first_vld  (w_f1_vld),
    .o_second     (w_s1),
    .o_second_vld (w_s1_vld)
  );

  always_comb begin
    w_emit = '0;
    if (w_f0_vld) w_emit = w_emit | elem_bit(w_blk0, w_f0);
    if (w_s0_vld) w_emit = w_emit | elem_bit(w_blk0, w_s0);
    if (w_f1_vld) w_emit = w_emit | elem_bit(w_blk1, w_f1);
    if (w_s1_vld) w_emit = w_emit | elem_bit(w_blk1, w_s1);
  end

  assign w_rem = w_src & ~w_emit;

  always_comb begin
    w_beat            = '0;
    w_beat.sel_level0 = {w_blk1, w_blk0};
    w_beat.sel_level1 = {w_s1, w_f1, w_s0, w_f0};
    w_beat.lane_vld   = {w_s1_vld, w_f1_vld, w_s0_vld, w_f0_vld};
    w_beat.last       = (w_rem == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_data       <= '0;
      r_pend       <= '0;
      r_beat       <= '0;
      r_beat_idx   <= '0;
`ifdef SPARSE_SEL_ZERO_SKIP_EN
      r_zero_pulse <= 1'b0;
`endif
    end else begin
`ifdef SPARSE_SEL_ZERO_SKIP_EN
      r_zero_pulse <= w_acc & w_zero_tile;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_state    <= S_BUSY;
            r_data     <= bus.in_data;
            r_beat     <= w_beat;
            r_pend     <= w_rem;
            r_beat_idx <= '0;
          end
        end
        S_BUSY: begin
          if (w_load) begin
            // Last beat consumed while a new tile arrives: no bubble.
            r_data     <= bus.in_data;
            r_beat     <= w_beat;
            r_pend     <= w_rem;
            r_beat_idx <= '0;
          end else if (w_hs) begin
            if (r_beat.last) begin
              r_state <= S_IDLE;
            end else begin
              r_beat     <= w_beat;
              r_pend     <= w_rem;
              r_beat_idx <= r_beat_idx + 2'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_valid;
  assign bus.out_data   = r_data;
  assign bus.sel_level0 = r_beat.sel_level0;
  assign bus.sel_level1 = r_beat.sel_level1;
  assign bus.lane_vld   = r_beat.lane_vld;
  assign bus.out_last   = r_beat.last;
  assign bus.beat_idx   = r_beat_idx;

endmodule

// File: tb/tb_sparse_sel_gen.sv
// ----------------------------------------------------------------------------
// tb_sparse_sel_gen
// Randomized and directed stimulus for sparse_sel_gen, checked every cycle
// against a greedy beat-list model of the tile mask.
// ----------------------------------------------------------------------------
module tb_sparse_sel_gen;

  localparam int ELEM_W = 8;
  localparam int DW     = 16 * ELEM_W;

  logic clk;
  logic rst_n;

  sparse_sel_gen_if #(.ELEM_W(ELEM_W)) bus ();

  sparse_sel_gen #(.ELEM_W(ELEM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [3:0]    sel0;
    logic [7:0]    sel1;
    logic [3:0]    lane;
    logic          last;
    logic [1:0]    idx;
  } exp_beat_t;

  exp_beat_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  logic exp_zero_pulse = 1'b0;

  task automatic check_eq(input string tag, input logic [DW-1:0] act,
                          input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Greedy reference: scan blocks low to high, take up to two blocks holding
  // pending bits, and up to two lowest pending elements in each.
  function automatic void model_tile(input logic [15:0] m, input logic [DW-1:0] d);
    logic [15:0] p;
    int          bi;
    p  = m;
    bi = 0;
`ifdef SPARSE_SEL_ZERO_SKIP_EN
    if (m == 16'h0) return;
`endif
    do begin
      exp_beat_t   b;
      logic [15:0] take;
      int          slot;
      b.data = d; b.sel0 = '0; b.sel1 = '0; b.lane = '0;
      take = '0;
      slot = 0;
      for (int blk = 0; blk < 4; blk++) begin
        int ne;
        ne = 0;
        if (slot < 2 && p[blk*4 +: 4] != 4'h0) begin
          b.sel0 = b.sel0 | 4'(blk << (2 * slot));
          for (int e = 0; e < 4; e++) begin
            if (ne < 2 && p[blk*4 + e]) begin
              b.sel1 = b.sel1 | 8'(e << (4 * slot + 2 * ne));
              b.lane[2 * slot + ne] = 1'b1;
              take[blk*4 + e] = 1'b1;
              ne++;
            end
          end
          slot++;
        end
      end
      p = p & ~take;
      b.last = (p == 16'h0);
      b.idx  = 2'(bi);
      bi++;
      exp_q.push_back(b);
    end while (p != 16'h0);
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Per-cycle monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_zero_pulse = 1'b0;
      check_eq("rst_out_valid", DW'(bus.out_valid), '0);
      check_eq("rst_in_ready",  DW'(bus.in_ready), DW'(1));
      check_eq("rst_out_data",  bus.out_data, '0);
      check_eq("rst_sel",       DW'({bus.sel_level0, bus.sel_level1, bus.lane_vld,
                                     bus.out_last, bus.beat_idx}), '0);
    end else begin
      logic exp_rdy;
      exp_rdy = (exp_q.size() == 0) || (bus.out_ready && exp_q[0].last);
      check_eq("out_valid", DW'(bus.out_valid), DW'(exp_q.size() != 0));
      check_eq("in_ready",  DW'(bus.in_ready), DW'(exp_rdy));
`ifdef SPARSE_SEL_ZERO_SKIP_EN
      check_eq("zero_tile_cnt", DW'(bus.zero_tile_cnt), DW'(exp_zero_pulse));
      exp_zero_pulse = bus.in_valid && bus.in_ready && (bus.in_mask == 16'h0);
`endif
      if (exp_q.size() != 0 && bus.out_valid) begin
        check_eq("out_data",   bus.out_data,        exp_q[0].data);
        check_eq("sel_level0", DW'(bus.sel_level0), DW'(exp_q[0].sel0));
        check_eq("sel_level1", DW'(bus.sel_level1), DW'(exp_q[0].sel1));
        check_eq("lane_vld",   DW'(bus.lane_vld),   DW'(exp_q[0].lane));
        check_eq("out_last",   DW'(bus.out_last),   DW'(exp_q[0].last));
        check_eq("beat_idx",   DW'(bus.beat_idx),   DW'(exp_q[0].idx));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) model_tile(bus.in_mask, bus.in_data);
    end
  end

  task automatic send_tile(input logic [15:0] m, input logic [DW-1:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_mask  = m;
    bus.in_data  = d;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        check_eq("accept_timeout", DW'(bus.in_ready), DW'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [15:0] rand_mask();
    logic [15:0] m;
    case ($urandom_range(0, 4))
      0:       m = 16'($urandom);
      1:       m = 16'($urandom & $urandom & $urandom);
      2:       m = 16'(1 << $urandom_range(0, 15));
      3:       m = 16'hFFFF;
      default: m = 16'($urandom & $urandom);
    endcase
    if ($urandom_range(0, 9) == 0) m = 16'h0;
    return m;
  endfunction

  initial begin
    int n;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_mask  = '0;
    bus.in_data  = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test-plan masks, back-to-back with continuous out_ready.
    rdy_mode = 0;
    send_tile(16'hFFFF, rand_data());
    send_tile(16'h0001, rand_data());
    send_tile(16'h8000, rand_data());
    send_tile(16'h0F01, rand_data());
    send_tile(16'h0000, rand_data());
    send_tile(16'h0F01, rand_data());

    // Backpressure for three cycles in the middle of a full tile.
    send_tile(16'hFFFF, rand_data());
    @(posedge clk);
    rdy_mode = 2;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_in_ready", DW'(bus.in_ready), '0);
    end
    rdy_mode = 0;
    repeat (6) @(posedge clk);
    #1;

    // Reset asserted during beat 1 of a full tile.
    send_tile(16'hFFFF, rand_data());
    @(posedge clk);
    #3;
    check_eq("pre_rst_beat_idx", DW'(bus.beat_idx), DW'(1));
    rst_n = 1'b0;
    #1;
    check_eq("rst_now_valid", DW'(bus.out_valid), '0);
    check_eq("rst_now_sel",   DW'({bus.sel_level0, bus.sel_level1, bus.lane_vld}), '0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", DW'(bus.in_ready), DW'(1));
    @(posedge clk);
    #1;
    send_tile(16'hFFFF, rand_data());

    // Random tiles with random gaps and random backpressure.
    rdy_mode = 1;
    for (int t = 0; t < 120; t++) begin
      send_tile(rand_mask(), rand_data());
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    rdy_mode = 0;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("drain_timeout", DW'(bus.out_valid), '0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sparse_sel_gen.md
# sparse_sel_gen

Sequential selection generator that sits directly upstream of the 16-to-4 two-level sparse mux. It accepts one 4x4 tile of 8-bit elements plus a 16-bit non-zero mask per handshake, then walks the mask over one to four output beats. Each beat drives the mux's `sel_level0`/`sel_level1` so that up to four non-zero elements reach the 32-bit mux output per cycle. The tile data is registered and held for the mux, alongside per-lane valid and last-beat flags for the downstream consumer.

## Interface
- `ELEM_W`, default 8: element width in bits.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `in_valid`  in  1: tile offered.
- `in_ready`  out  1: tile accepted when `in_valid & in_ready`.
- `in_data`  in  16*ELEM_W: tile; element i at `[i*ELEM_W +: ELEM_W]`; block b = elements 4b..4b+3.
- `in_mask`  in  16: bit i set = element i non-zero.
- `out_valid`  out  1: beat valid.
- `out_ready`  in  1: beat consumed when `out_valid & out_ready`.
- `out_data`  out  16*ELEM_W: registered tile, held for all beats of the tile; feeds mux `in`.
- `sel_level0`  out  4: `[1:0]` = slot-0 block, `[3:2]` = slot-1 block.
- `sel_level1`  out  8: `[1:0]`/`[3:2]` = slot-0 first/second element; `[5:4]`/`[7:6]` = slot-1 first/second element.
- `lane_vld`  out  4: bit k = mux output byte k carries a real element (bit order out0..out3).
- `out_last`  out  1: final beat of the tile.
- `beat_idx`  out  2: beat number within the tile, 0-based.

## Operation
- **State.** Two states, IDLE (no pending tile) and BUSY. BUSY holds the `pend` mask register.
- **Accept.** On accept, `pend <= in_mask` and `out_data <= in_data`, and the state goes to BUSY.
- **Beat formation** (combinational from `pend`, registered into the outputs):
  - slot0 = lowest block index with `pend` bits set; slot1 = next such block.
  - Within each slot, first = lowest set element, second = next set element.
  - Unused block or element fields drive 0, and the matching `lane_vld` bit is 0.
- **Consume.** On a beat handshake, the `pend` bits of the emitted elements are cleared.
  - `out_last` = 1 when `pend` after clearing is zero.
  - `beat_idx` increments per beat and resets to 0 on each new tile.
- **Beat count.** Greedy order guarantees at most 4 beats per tile, so `beat_idx` never wraps.
- **Completion.** After the last beat is consumed, BUSY goes to IDLE, or stays BUSY if a new tile is accepted in the same cycle.
- **All-zero mask.** One beat with `lane_vld = 0`, all selects 0, `out_last = 1` (but see Configuration).
- **`in_ready`.** Equals `~out_valid | (out_valid & out_ready & out_last)`. This allows back-to-back tiles with no bubble.
- **Output stability.** While `out_valid & ~out_ready`, every output is held stable.
- **Reset.** Reset mid-tile discards `pend` and the tile. All outputs reset to 0, except `in_ready`, which is 1 after reset.

## Timing
- Tile accepted at edge N → first beat has `out_valid` = 1 after edge N.
- Each subsequent beat follows one cycle after the previous beat's handshake.
- Throughput: one beat per cycle under continuous `out_ready`; a tile occupies 1–4 cycles.
- Simultaneous last-beat handshake and new-tile accept: the new tile's beat 0 is presented the very next cycle.
- All outputs are registered; the only combinational path is `out_valid`/`out_ready`/`out_last` → `in_ready`.

## Configuration
- **`SPARSE_SEL_ZERO_SKIP_EN` defined:**
  - An all-zero tile is accepted and dropped; no beat is emitted.
  - `in_ready` stays 1 for it.
  - A 1-bit `zero_tile_cnt` pulse output appears for accounting.
- **Undefined:** the all-zero tile emits one empty last beat as described in Operation.

## Structure
- Package `sparse_pkg`:
  - `TILE_ELEMS` = 16, `BLK_ELEMS` = 4.
  - Block/element index typedefs (2-bit).
  - Beat record typedef `{sel_level0, sel_level1, lane_vld, last}`.
- Sub-module `lead2_pick`: 4-bit vector in, first/second set-bit index plus two valid flags out.
  - Instantiated once for block selection.
  - Instantiated twice for element selection (one per slot).

## Test plan
- **Full tile.** Mask 16'hFFFF → 4 beats, all with `lane_vld` = 4'hF; `out_last` only on beat 3:
  - (`sel_level0`, `sel_level1`) = (4'h4, 8'h44), (4'h4, 8'hEE), (4'hE, 8'h44), (4'hE, 8'hEE).
- **Single elements.**
  - Mask 16'h0001 → one beat: `sel_level0` = 0, `sel_level1` = 0, `lane_vld` = 4'b0001, `out_last` = 1.
  - Mask 16'h8000 → one beat: `sel_level0` = 4'h3, `sel_level1` = 8'h03, `lane_vld` = 4'b0001.
- **Skewed tile.** Mask 16'h0F01 → beat0 `sel_level0` = 4'h8, `sel_level1` = 8'h40, `lane_vld` = 4'b1101; beat1 `sel_level0` = 4'h2, `sel_level1` = 8'h0E, `lane_vld` = 4'b0011, last.
- **Backpressure.** `out_ready` low 3 cycles mid-tile → outputs bit-stable, `in_ready` = 0. Back-to-back tiles with `out_ready` = 1 → no idle cycle between tiles.
- **Zero tile.** Mask 16'h0000 → empty last beat without the macro; no beat plus a `zero_tile_cnt` pulse with the macro.
- **Reset mid-tile.** `rst_n` low during beat 1 of 16'hFFFF → outputs 0 immediately, `in_ready` = 1 after release, next tile starts at `beat_idx` 0.
